// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types, constants and rotating priority search for rr_arb8
package rr_arb_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  // First set request bit scanning ptr, ptr+1, ... with modulo-8 wrap.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/onehot_dec3x8.sv
// rtl/onehot_dec3x8.sv - combinational 3-to-8 one-hot decoder
module onehot_dec3x8
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = N_REQ'(1) << idx;
  end

endmodule

// File: rtl/rr_arb8.sv
// rtl/rr_arb8.sv - eight-way round-robin arbiter with hold timeout
module rr_arb8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int CNT_W = $clog2(MAX_HOLD);

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] idx_n;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic             timeout_n;
  logic             cnt_max;
  logic             rel;
  logic [N_REQ-1:0] dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_idx  <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= cnt_n;
      gnt_idx  <= idx_n;
      timeout  <= timeout_n;
    end
  end

  assign cnt_max = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign rel     = done || !req[gnt_idx] || cnt_max;

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = hold_cnt;
    idx_n     = gnt_idx;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_n   = rr_pick(req, ptr);
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (rel) begin
          state_n   = IDLE;
          ptr_n     = gnt_idx + IDX_W'(1);
          // Timeout only flags revocations the holder did not cause itself.
          timeout_n = cnt_max && !done && req[gnt_idx];
        end else begin
          cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign gnt_valid = (state == GRANT);

  onehot_dec3x8 u_dec (
    .idx    (gnt_idx),
    .onehot (dec)
  );

  assign gnt = dec & {N_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_arb8.sv
// tb/tb_rr_arb8.sv - randomized and directed self-checking bench for rr_arb8
module tb_rr_arb8;

  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  // Reference: who holds the resource, how many cycles it has held it,
  // where the next search starts, and whether a hold-limit revocation just happened.
  int m_holder;
  int m_idx;
  int m_held;
  int m_ptr;
  bit m_to;

  rr_arb8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_idx    = 0;
    m_held   = 0;
    m_ptr    = 0;
    m_to     = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    bit found;
    m_to = 1'b0;
    if (m_holder < 0) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (m_ptr + k) % 8;
        if (!found && r[j]) begin
          found    = 1'b1;
          m_holder = j;
          m_idx    = j;
          m_held   = 1;
        end
      end
    end else if (d || !r[m_holder] || m_held == MAX_HOLD) begin
      m_to     = (m_held == MAX_HOLD) && !d && r[m_holder];
      m_ptr    = (m_holder + 1) % 8;
      m_holder = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic compare_model();
    logic [7:0] exp_gnt;
    exp_gnt = (m_holder >= 0) ? (8'h01 << m_holder) : 8'h00;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("gnt_valid", 32'(gnt_valid), 32'(m_holder >= 0));
    chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  // Called at a negedge: drive inputs for the next rising edge, then compare after it.
  task automatic cyc(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    logic [7:0] r;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);

    rst = 1'b0;
    cyc(8'hFF, 1'b0);
    chk("first_idx", 32'(gnt_idx), 32'h0);
    chk("first_gnt", 32'(gnt), 32'h01);

    // Rotation: each holder keeps the grant 3 cycles, then one idle cycle.
    for (int g = 0; g < 9; g++) begin
      chk("rot_idx", 32'(gnt_idx), 32'(g % 8));
      cyc(8'hFF, 1'b0);
      cyc(8'hFF, 1'b0);
      chk("rot_hold", 32'(gnt_valid), 32'h1);
      cyc(8'hFF, 1'b1);
      chk("rot_gap", 32'(gnt_valid), 32'h0);
      cyc(8'hFF, 1'b0);
    end

    // Skip and wrap: holder 6 releases, then only 0 and 2 request.
    cyc(8'hFF, 1'b1);
    cyc(8'h40, 1'b0);
    chk("skip_6", 32'(gnt_idx), 32'h6);
    cyc(8'h05, 1'b0);
    cyc(8'h05, 1'b0);
    chk("wrap_0", 32'(gnt_idx), 32'h0);
    cyc(8'h05, 1'b1);
    cyc(8'h05, 1'b0);
    chk("next_2", 32'(gnt_idx), 32'h2);
    cyc(8'h00, 1'b1);

    // Hold limit: requester 3 never releases.
    cyc(8'h08, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++) begin
      chk("to_held", 32'(gnt), 32'h08);
      cyc(8'h08, 1'b0);
    end
    chk("to_last", 32'(gnt), 32'h08);
    cyc(8'h08, 1'b0);
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_valid", 32'(gnt_valid), 32'h0);
    cyc(8'h08, 1'b0);
    chk("to_regrant", 32'(gnt_idx), 32'h3);
    chk("to_clear", 32'(timeout), 32'h0);

    // Simultaneous release on the final allowed hold cycle.
    for (int i = 1; i < MAX_HOLD; i++) cyc(8'h08, 1'b0);
    cyc(8'h00, 1'b1);
    chk("sim_no_to", 32'(timeout), 32'h0);
    chk("sim_valid", 32'(gnt_valid), 32'h0);
    cyc(8'hFF, 1'b0);
    chk("sim_ptr", 32'(gnt_idx), 32'h4);

    // Asynchronous reset while requester 5 holds.
    cyc(8'h20, 1'b0);
    cyc(8'h20, 1'b0);
    chk("ar_gnt", 32'(gnt), 32'h20);
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt0", 32'(gnt), 32'h0);
    chk("ar_valid0", 32'(gnt_valid), 32'h0);
    chk("ar_to0", 32'(timeout), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(8'h20, 1'b0);
    chk("ar_regrant", 32'(gnt_idx), 32'h5);

    // Random phases: churning requests, then sticky requests that hit the hold limit.
    r = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ((n / 60) % 2 == 0) begin
        r = 8'($urandom);
        if ($urandom_range(0, 5) == 0) r = 8'h00;
        cyc(r, $urandom_range(0, 5) == 0);
      end else begin
        if (n % 60 == 0) r = 8'($urandom_range(1, 255));
        cyc(r, $urandom_range(0, 40) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
